// File: rtl/matrix_ctrl_pkg.sv
// rtl/matrix_ctrl_pkg.sv - shared types and constants for the MAC ALU sequencer
package matrix_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int X_BYTES      = 9;
  localparam int BYTE_W       = 8;
  localparam int XREG_W       = 24;
  localparam int ALU_A_W      = 72;
  localparam int BCNT_W       = 4;
  localparam int RD_LAT       = 1;
  localparam int ALU_EN_DLY   = RD_LAT;
  localparam int RES_ADDR_DLY = RD_LAT + 1;

endpackage

// File: rtl/matrix_ctrl_if.sv
// rtl/matrix_ctrl_if.sv - X byte input, ROM/ALU control and status bundle
interface matrix_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              a_re;
  logic [ADDR_W-1:0] a_addr;
  logic              alu_en;
  logic [23:0]       x_reg1;
  logic [23:0]       x_reg2;
  logic [23:0]       x_reg3;
  logic [ADDR_W-1:0] res_addr;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_data,
    input  a_re, a_addr, alu_en, x_reg1, x_reg2, x_reg3, res_addr, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output a_re, a_addr, alu_en, x_reg1, x_reg2, x_reg3, res_addr, busy, done
  );
endinterface

// File: rtl/matrix_ctrl_x_loader.sv
// rtl/matrix_ctrl_x_loader.sv - byte counter and the three packed X registers
module matrix_ctrl_x_loader
  import matrix_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              last_o,
  output logic [XREG_W-1:0] x_reg1_o,
  output logic [XREG_W-1:0] x_reg2_o,
  output logic [XREG_W-1:0] x_reg3_o
);

  logic [ALU_A_W-1:0] x_q;
  logic [BCNT_W-1:0]  byte_cnt_q;

  // Byte k lands at bit 8*k of the flat vector, which splits into x_reg1..3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= '0;
      byte_cnt_q <= '0;
    end else if (clr_i) begin
      x_q        <= '0;
      byte_cnt_q <= '0;
    end else if (load_i) begin
      for (int k = 0; k < X_BYTES; k++) begin
        if (byte_cnt_q == BCNT_W'(k)) x_q[k*BYTE_W +: BYTE_W] <= data_i;
      end
      byte_cnt_q <= byte_cnt_q + 1'b1;
    end
  end

  assign last_o   = load_i && (byte_cnt_q == BCNT_W'(X_BYTES - 1));
  assign x_reg1_o = x_q[0*XREG_W +: XREG_W];
  assign x_reg2_o = x_q[1*XREG_W +: XREG_W];
  assign x_reg3_o = x_q[2*XREG_W +: XREG_W];

endmodule

// File: rtl/matrix_ctrl.sv
// rtl/matrix_ctrl.sv - loads the X vector, streams A rows from ROM and tags results
module matrix_ctrl
  import matrix_ctrl_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  matrix_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
  logic              drain_cnt_q, drain_cnt_d;
  logic              busy_q, done_q;
  logic              x_clr, x_load, x_last;
  logic              a_re;
  logic [ADDR_W-1:0] a_addr;
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_pipe_q [RES_ADDR_DLY];

  assign x_clr  = (state_q == ST_IDLE) && bus.start;
  assign x_load = (state_q == ST_LOAD_X) && bus.in_valid;
  assign a_re   = (state_q == ST_RUN);
  assign a_addr = row_cnt_q;

  matrix_ctrl_x_loader u_x_loader (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (x_clr),
    .load_i   (x_load),
    .data_i   (bus.in_data),
    .last_o   (x_last),
    .x_reg1_o (bus.x_reg1),
    .x_reg2_o (bus.x_reg2),
    .x_reg3_o (bus.x_reg3)
  );

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_LOAD_X;
      ST_LOAD_X: begin
        if (x_last) begin
          state_d   = ST_RUN;
          row_cnt_d = '0;
        end
      end
      ST_RUN: begin
        row_cnt_d = row_cnt_q + 1'b1;
        if (row_cnt_q == LAST_ROW) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      // Two cycles flush the last alu_en and the ALU's registered write.
      ST_DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      drain_cnt_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_q       <= '0;
      for (int i = 0; i < RES_ADDR_DLY; i++) addr_pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_q == ST_DONE);
      vld_q[0]    <= a_re;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      // Address stages only advance with a valid row, so res_addr holds between runs.
      if (a_re) addr_pipe_q[0] <= a_addr;
      for (int i = 1; i < RES_ADDR_DLY; i++) begin
        if (vld_q[i-1]) addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign bus.a_re     = a_re;
  assign bus.a_addr   = a_addr;
  assign bus.alu_en   = vld_q[ALU_EN_DLY-1];
  assign bus.res_addr = addr_pipe_q[RES_ADDR_DLY-1];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_matrix_ctrl.sv
// tb/tb_matrix_ctrl.sv - self-checking bench for matrix_ctrl
module tb_matrix_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_ctrl_if #(.ADDR_W(8)) b8 ();
  matrix_ctrl_if #(.ADDR_W(8)) b1 ();

  matrix_ctrl #(.ROWS(8), .ADDR_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  matrix_ctrl #(.ROWS(1), .ADDR_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct {
    logic [8:0][7:0] b;
    logic [23:0]     e1;
    logic [23:0]     e2;
    logic [23:0]     e3;
    int              gap;
    bit              spur;
    bit              keep;
  } vec_t;

  vec_t       v [4];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];
  logic       prev_are = 1'b0;
  logic       prev_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: rows pushed on issue, popped when the ALU write enable would fire.
  always @(negedge clk) begin
    if (!rst) begin
      prev_are = 1'b0;
      prev_en  = 1'b0;
      exp_q.delete();
    end else begin
      chk("alu_en_delay", 32'(b8.alu_en), 32'(prev_are));
      if (prev_en) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL res_addr_unexpected: got 0x%0h expected no result", b8.res_addr);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("res_addr", 32'(b8.res_addr), 32'(e));
        end
      end
      prev_are = b8.a_re;
      prev_en  = b8.alu_en;
    end
  end

  task automatic feed8(input int i);
    for (int k = 0; k < 9; k++) begin
      b8.in_valid = 1'b1;
      b8.in_data  = v[i].b[k];
      tick();
      if (k < 8) begin
        b8.in_valid = 1'b0;
        b8.in_data  = 8'hEE;
        for (int g = 0; g < v[i].gap; g++) begin
          chk("a_re_in_load", 32'(b8.a_re), 0);
          tick();
        end
      end
    end
  endtask

  task automatic do_run(input int i);
    int cnt;
    b8.start = 1'b1;
    tick();
    b8.start = v[i].keep;
    chk("busy_after_start", 32'(b8.busy), 1);
    chk("x1_cleared", 32'(b8.x_reg1), 0);
    chk("x3_cleared", 32'(b8.x_reg3), 0);
    feed8(i);
    b8.in_valid = v[i].spur;
    b8.in_data  = 8'hEE;
    chk("x_reg1", 32'(b8.x_reg1), 32'(v[i].e1));
    chk("x_reg2", 32'(b8.x_reg2), 32'(v[i].e2));
    chk("x_reg3", 32'(b8.x_reg3), 32'(v[i].e3));
    for (int r = 0; r < 8; r++) begin
      chk("a_re_run", 32'(b8.a_re), 1);
      chk("a_addr", 32'(b8.a_addr), r);
      chk("busy_run", 32'(b8.busy), 1);
      exp_q.push_back(8'(r));
      tick();
    end
    cnt = 8;
    while (!b8.done && cnt < 40) begin
      chk("a_re_after_run", 32'(b8.a_re), 0);
      tick();
      cnt++;
    end
    chk("done_latency", cnt, 11);
    chk("busy_with_done", 32'(b8.busy), 0);
    chk("x1_held", 32'(b8.x_reg1), 32'(v[i].e1));
    chk("scoreboard_drained", exp_q.size(), 0);
    b8.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b8.start = 1'b0; b8.in_valid = 1'b0; b8.in_data = 8'h00;
    b1.start = 1'b0; b1.in_valid = 1'b0; b1.in_data = 8'h00;

    v[0] = '{b: 72'h090807060504030201, e1: 24'h030201, e2: 24'h060504, e3: 24'h090807,
             gap: 0, spur: 1'b0, keep: 1'b0};
    v[1] = '{b: 72'h998877665544332211, e1: 24'h332211, e2: 24'h665544, e3: 24'h998877,
             gap: 2, spur: 1'b1, keep: 1'b0};
    v[2] = '{b: 72'hFF00FF00FF00FF00FF, e1: 24'hFF00FF, e2: 24'h00FF00, e3: 24'hFF00FF,
             gap: 1, spur: 1'b0, keep: 1'b1};
    v[3] = '{b: 72'hA5C3E75A3C180F1E2D, e1: 24'h0F1E2D, e2: 24'h5A3C18, e3: 24'hA5C3E7,
             gap: 0, spur: 1'b1, keep: 1'b0};

    repeat (2) tick();
    chk("rst_a_re", 32'(b8.a_re), 0);
    chk("rst_a_addr", 32'(b8.a_addr), 0);
    chk("rst_busy", 32'(b8.busy), 0);
    chk("rst_done", 32'(b8.done), 0);
    chk("rst_res_addr", 32'(b8.res_addr), 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(b8.busy), 0);

    do_run(0);
    do_run(1);

    // Reset while row 3 of 8 is being issued.
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    feed8(0);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(8'(r));
      tick();
    end
    chk("pre_rst_a_addr", 32'(b8.a_addr), 3);
    chk("pre_rst_res_addr", 32'(b8.res_addr), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_a_re", 32'(b8.a_re), 0);
    chk("mid_rst_a_addr", 32'(b8.a_addr), 0);
    chk("mid_rst_alu_en", 32'(b8.alu_en), 0);
    chk("mid_rst_res_addr", 32'(b8.res_addr), 0);
    chk("mid_rst_busy", 32'(b8.busy), 0);
    chk("mid_rst_x1", 32'(b8.x_reg1), 0);
    chk("mid_rst_x3", 32'(b8.x_reg3), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_a_re", 32'(b8.a_re), 0);

    do_run(0);
    do_run(2);
    do_run(3);
    tick();
    chk("done_one_cycle", 32'(b8.done), 0);
    chk("no_restart_busy", 32'(b8.busy), 0);
    chk("no_restart_a_re", 32'(b8.a_re), 0);

    // Single-row configuration.
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      b1.in_valid = 1'b1;
      b1.in_data  = 8'(8'h10 + k);
      tick();
    end
    b1.in_valid = 1'b0;
    chk("r1_a_re", 32'(b1.a_re), 1);
    chk("r1_a_addr", 32'(b1.a_addr), 0);
    chk("r1_x_reg2", 32'(b1.x_reg2), 32'h151413);
    tick();
    chk("r1_a_re_off", 32'(b1.a_re), 0);
    chk("r1_alu_en", 32'(b1.alu_en), 1);
    tick();
    chk("r1_alu_en_off", 32'(b1.alu_en), 0);
    chk("r1_res_addr", 32'(b1.res_addr), 0);
    tick();
    chk("r1_done_early", 32'(b1.done), 0);
    chk("r1_busy_early", 32'(b1.busy), 1);
    tick();
    chk("r1_done", 32'(b1.done), 1);
    chk("r1_busy_with_done", 32'(b1.busy), 0);
    tick();
    chk("r1_done_pulse", 32'(b1.done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
